// File: rtl/sipo_to_piso_conv.sv
// Serial re-timing buffer: a SIPO stage assembles WIDTH-bit words, each completed word is
// handed to a PISO stage that replays it while the next word fills (constant WIDTH-cycle delay).
module sipo_to_piso_conv #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out,
  output logic filled_up
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sipo_reg;
  logic [WIDTH-1:0] piso_reg;
  logic [WIDTH-1:0] sipo_next;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             out_active;
  logic             xfer;

  // The first received bit ends up at the end of the word that is transmitted first.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b);
    if (MSB_FIRST) return {word[WIDTH-2:0], b};
    else           return {b, word[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) return {word[WIDTH-2:0], 1'b0};
    else           return {1'b0, word[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) return word[WIDTH-1];
    else           return word[0];
  endfunction

  always_comb begin
    sipo_next = shift_in(sipo_reg, serial_in);
    xfer      = (in_cnt == LAST);
  end

  // Transfer loads the bypassed shift value so the bit sampled on the last edge is included;
  // it also overrides the PISO shift, keeping the output gapless across word boundaries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sipo_reg   <= '0;
      piso_reg   <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      out_active <= 1'b0;
      filled_up  <= 1'b0;
    end else begin
      sipo_reg  <= sipo_next;
      in_cnt    <= xfer ? '0 : in_cnt + ONE;
      filled_up <= xfer;
      if (xfer) begin
        piso_reg   <= sipo_next;
        out_cnt    <= '0;
        out_active <= 1'b1;
      end else if (out_active) begin
        piso_reg <= shift_out(piso_reg);
        out_cnt  <= out_cnt + ONE;
        if (out_cnt == LAST) out_active <= 1'b0;
      end
    end
  end

  assign serial_out = out_active ? out_bit(piso_reg) : 1'b0;

endmodule

// File: tb/tb_sipo_to_piso_conv.sv
// Bench for sipo_to_piso_conv: an MSB-first and an LSB-first instance share one stimulus
// stream; a delay-line model checks both every cycle, directed literals pin the model.
module tb_sipo_to_piso_conv;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b0;
  logic so_msb, fu_msb, so_lsb, fu_lsb;

  int checks = 0;
  int errors = 0;

  sipo_to_piso_conv #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(so_msb), .filled_up(fu_msb)
  );
  sipo_to_piso_conv #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(so_lsb), .filled_up(fu_lsb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: output is the input stream since reset release delayed by W cycles;
  // a word boundary is flagged after every W-th sampled bit.
  logic hist[$];
  always @(posedge clk) begin
    logic r, b, eo, ef;
    r = rst;
    b = serial_in;
    #1;
    if (!r) hist.delete();
    else hist.push_back(b);
    eo = (hist.size() >= W) ? hist[hist.size() - W] : 1'b0;
    ef = (hist.size() > 0) && (hist.size() % W == 0);
    chk("model_out_msb", so_msb, eo);
    chk("model_out_lsb", so_lsb, eo);
    chk("model_fill_msb", fu_msb, ef);
    chk("model_fill_lsb", fu_lsb, ef);
  end

  task automatic drive(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    serial_in = b;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] pat;
    int pulses;
    int wait_cyc;
    bit seen;
    pat = 8'b1011_0010;

    // Reset hold with random input
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)));
      chk("rst_out", so_msb, 1'b0);
      chk("rst_fill", fu_msb, 1'b0);
      chk("rst_in_cnt", 32'(u_msb.in_cnt), 0);
      chk("rst_out_cnt", 32'(u_lsb.out_cnt), 0);
    end

    // Single word 1,0,1,1,0,0,1,0
    for (int i = 0; i < W; i++) begin
      drive(1'b1, pat[7-i]);
      chk("word_fill", fu_msb, (i == W - 1));
      if (i < W - 1) chk("word_out_quiet", so_msb, 1'b0);
    end
    chk("piso_msb", 32'(u_msb.piso_reg), 32'hB2);
    chk("piso_lsb", 32'(u_lsb.piso_reg), 32'h4D);
    chk("word_first_bit", so_msb, 1'b1);
    for (int i = 0; i < W; i++) begin
      if (i > 0) chk("word_out", so_msb, pat[7-i]);
      drive(1'b1, 1'b0);
      if (i == 0) chk("word_fill_once", fu_msb, 1'b0);
    end

    // Streaming 32 random bits starting on a word boundary
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      if (fu_msb) pulses++;
    end
    chk("stream_pulses", pulses, 4);

    // Reset after 13 bits, then measure the gap to the next word boundary
    for (int i = 0; i < 13; i++) drive(1'b1, 1'($urandom_range(0, 1)));
    drive(1'b0, 1'b1);
    chk("midrst_out", so_msb, 1'b0);
    chk("midrst_fill", fu_msb, 1'b0);
    wait_cyc = 0;
    seen = 1'b0;
    while (!seen && wait_cyc < 20) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      wait_cyc++;
      if (fu_msb) seen = 1'b1;
    end
    chk("midrst_seen", seen, 1'b1);
    chk("midrst_gap", wait_cyc, W);

    // Constant ones after a fresh reset
    drive(1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1);
      chk("const_out", so_msb, (i >= 8));
      chk("const_fill", fu_msb, (i == 8 || i == 16));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
